// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: sequences one full-adder slice over WIDTH-bit operands, one bit per clock.
// Optional subtract mode (invert B, carry-in 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;
  logic             load, last, p, bit_s, cy;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld   = sub ? ~b : b;
  assign cin_ld = sub;
`else
  logic unused_sub;
  assign b_ld       = b;
  assign cin_ld     = 1'b0;
  assign unused_sub = sub;
`endif

  assign load = (state_q != SHIFT) && start;
  assign last = (cnt_q == LAST);

  // Shared one-bit slice: two half adders plus carry OR.
  assign p     = a_q[0] ^ b_q[0];
  assign bit_s = p ^ carry_q;
  assign cy    = (a_q[0] & b_q[0]) | (p & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last)  state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (load) begin
      a_d     = a;
      b_d     = b_ld;
      carry_d = cin_ld;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = cy;
      res_d   = {bit_s, res_q[WIDTH-1:1]};
      if (last) begin
        sum_d  = {bit_s, res_q[WIDTH-1:1]};
        cout_d = cy;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): latency, handshake, start masking,
// async reset abort and add/sub behaviour under the SERIAL_ADDER_SUB_EN build option.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, start, sub;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;
  int         n_chk = 0, n_fail = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Accept one operation and wait for done; lat = edges after acceptance, -1 on timeout.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       output logic [7:0] s, output logic c, output int lat);
    a = ia; b = ib; sub = isub; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin lat = i; break; end
    end
    s = sum; c = cout;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    #12;
    n_chk++; if ({busy, done, cout} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl busy/done/cout=%b want 000", {busy, done, cout}); end
    n_chk++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
    tick(); rst_n = 1'b1; tick();
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset busy/done=%b want 00", {busy, done}); end
  endtask

  task automatic test_add();
    int busy_cyc = 0;
    a = 8'h0F; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (busy) busy_cyc++;
      n_chk++; if (done !== 1'b0 || sum !== 8'h00) begin n_fail++; $display("FAIL add_hold before E%0d done=%b sum=%h want 0/00", i, done, sum); end
      tick();
    end
    n_chk++; if (busy_cyc != 8) begin n_fail++; $display("FAIL add_busy_len got %0d want 8", busy_cyc); end
    n_chk++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL add_done_E8 busy/done=%b want 01", {busy, done}); end
    n_chk++; if (sum !== 8'h10 || cout !== 1'b0) begin n_fail++; $display("FAIL add_result sum=%h cout=%b want 10/0", sum, cout); end
    tick();
    n_chk++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL add_done_pulse busy/done=%b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    a = 8'hFF; b = 8'h01; start = 1'b1;
    tick();
    a = 8'h00; b = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin lat = i; break; end
    end
    n_chk++; if (lat != 8) begin n_fail++; $display("FAIL b2b_lat1 got %0d want 8", lat); end
    n_chk++; if (sum !== 8'h00 || cout !== 1'b1) begin n_fail++; $display("FAIL b2b_res1 sum=%h cout=%b want 00/1", sum, cout); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 4) begin
        n_chk++; if (busy !== 1'b1 || cout !== 1'b1) begin n_fail++; $display("FAIL b2b_hold busy=%b cout=%b want 1/1", busy, cout); end
      end
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    n_chk++; if (lat != 9) begin n_fail++; $display("FAIL b2b_spacing got %0d want 9", lat); end
    n_chk++; if (sum !== 8'h00 || cout !== 1'b0) begin n_fail++; $display("FAIL b2b_res2 sum=%h cout=%b want 00/0", sum, cout); end
    tick();
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    logic [7:0] s = 8'hxx;
    logic c = 1'bx;
    a = 8'h12; b = 8'h34; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 4; i <= 18; i++) begin
      tick();
      if (done) begin ndone++; s = sum; c = cout; end
    end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", ndone); end
    n_chk++; if (s !== 8'h46 || c !== 1'b0) begin n_fail++; $display("FAIL ign_result sum=%h cout=%b want 46/0", s, c); end
  endtask

  task automatic test_reset_abort();
    int ndone = 0;
    a = 8'hF0; b = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, done, cout} !== 3'b000 || sum !== 8'h00) begin n_fail++; $display("FAIL abort_async busy/done/cout=%b sum=%h want 000/00", {busy, done, cout}, sum); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    n_chk++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_done activity cycles=%0d want 0", ndone); end
  endtask

  task automatic test_sub();
    logic [7:0] s;
    logic c;
    int lat;
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, s, c, lat);
    n_chk++; if (s !== 8'hFE || c !== 1'b0 || lat != 8) begin n_fail++; $display("FAIL sub_borrow sum=%h cout=%b lat=%0d want FE/0/8", s, c, lat); end
    do_op(8'h07, 8'h05, 1'b1, s, c, lat);
    n_chk++; if (s !== 8'h02 || c !== 1'b1 || lat != 8) begin n_fail++; $display("FAIL sub_noborrow sum=%h cout=%b lat=%0d want 02/1/8", s, c, lat); end
    do_op(8'h05, 8'h07, 1'b0, s, c, lat);
    n_chk++; if (s !== 8'h0C || c !== 1'b0 || lat != 8) begin n_fail++; $display("FAIL sub0_add sum=%h cout=%b lat=%0d want 0C/0/8", s, c, lat); end
`else
    do_op(8'h05, 8'h07, 1'b1, s, c, lat);
    n_chk++; if (s !== 8'h0C || c !== 1'b0 || lat != 8) begin n_fail++; $display("FAIL sub_ignored sum=%h cout=%b lat=%0d want 0C/0/8", s, c, lat); end
    do_op(8'h80, 8'h81, 1'b1, s, c, lat);
    n_chk++; if (s !== 8'h01 || c !== 1'b1 || lat != 8) begin n_fail++; $display("FAIL sub_ignored_cy sum=%h cout=%b lat=%0d want 01/1/8", s, c, lat); end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_sub();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add controller that sequences a single one-bit adder slice (two half adders plus carry OR) across WIDTH-bit operands, one bit per clock. It sits between a requester presenting parallel operands and the shared one-bit adder datapath, owning operand capture, carry storage, bit counting and result assembly. A start/done handshake frames each operation; the result is presented in parallel on completion.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- sub  in  1  subtract select; captured with operands. Ignored unless SERIAL_ADDER_SUB_EN is defined.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  registered result, valid from done onward.
- cout  out  1  registered carry out of the MSB.
- One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE/DONE with start=1: load A and B shift registers, clear the carry, clear bit counter, go to SHIFT, busy=1.
- SHIFT, each edge: bit = A[0]^B[0]^carry; carry = (A[0]&B[0]) | ((A[0]^B[0])&carry); shift bit into result register MSB; shift A and B right; counter+1.
- After the WIDTH-th SHIFT edge: copy result register to sum, carry to cout, go to DONE, done=1, busy=0.
- DONE: done high for exactly one cycle. Next edge goes to IDLE, or directly back to SHIFT if start=1.
- start while in SHIFT is ignored; no queuing.
- Operands changing on a/b/sub during SHIFT have no effect.
- sum and cout keep the previous result throughout SHIFT. They change only on the completion edge.
- Counter width is ceil(log2(WIDTH)) bits. It terminates at WIDTH-1 and never wraps mid-operation.
- Reset asserted at any time, including mid-SHIFT, returns to IDLE immediately. busy=0, done=0, sum=0, cout=0, and internal registers are cleared. The aborted operation produces no done.

## Timing
- Accepting edge E0 (start=1, busy=0). Edges E1..EWIDTH process bits 0..WIDTH-1.
- busy rises after E0 and falls after EWIDTH.
- done and a new sum/cout appear after EWIDTH. Latency is WIDTH cycles from acceptance.
- done falls after E(WIDTH+1).
- Back-to-back throughput: one operation per WIDTH+1 cycles, with start held high.
- All outputs are registered; no combinational path from input to output.
- Reset values: busy=0, done=0, sum=0, cout=0.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub=1 at acceptance inverts the captured B and initialises the carry to 1, giving A−B in two's complement.
  - In this mode cout=1 means no borrow.
  - sub=0 behaves as a plain add.
- SERIAL_ADDER_SUB_EN undefined: sub is ignored, B is never inverted, and the initial carry is always 0.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, start pulse: busy high for 8 cycles; sum=0x10, cout=0; done is a single-cycle pulse after E8.
- a=0xFF, b=0x01: sum=0x00, cout=1. Then a=0x00, b=0x00 back-to-back with start held high: second done arrives 9 cycles after the first, with sum=0x00, cout=0.
- Start a=0x12, b=0x34. At E3 drive a=0xFF and pulse start: ignored. Result is sum=0x46, cout=0, and exactly one done pulse occurs.
- Start an operation, assert rst_n=0 at E4: busy, done, sum and cout all go to 0 without a clock edge. After release, no done appears until a new start.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x05, b=0x07 → sum=0xFE, cout=0.
  - a=0x07, b=0x05 → sum=0x02, cout=1.
- SERIAL_ADDER_SUB_EN undefined, sub=1, a=0x05, b=0x07 → sum=0x0C, cout=0.
